// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared DVS sensor constants and types.
//   DVS_X_ADDR_BITS / DVS_Y_ADDR_BITS : pixel address widths
//   TIMESTAMP_US_BITS                 : microsecond timestamp width
//   dvs_event_t                       : packed {x, y, ts, pol} event record
//   dvs_port_e                        : camera port identifier
package dvs_ravens_pkg;

  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 32;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] ts;
    logic                         pol;
  } dvs_event_t;

  typedef enum logic {
    PORT_LEFT  = 1'b0,
    PORT_RIGHT = 1'b1
  } dvs_port_e;

endpackage

// File: rtl/dvs_event_arbiter_if.sv
// dvs_event_arbiter_if: event input/output bundle of the two-camera arbiter.
//   in_new_event[p], in_event_x/y/ts/pol[p] : per-port event strobe + fields
//   out_valid/out_ready                     : merged-event handshake
//   out_x/out_y/out_ts/out_pol/out_src      : merged event, out_src = port
// Modports: slave = arbiter side, master = event source / sink side.
interface dvs_event_arbiter_if;
  import dvs_ravens_pkg::*;

  logic [1:0]                   in_new_event;
  logic [DVS_X_ADDR_BITS-1:0]   in_event_x   [2];
  logic [DVS_Y_ADDR_BITS-1:0]   in_event_y   [2];
  logic [TIMESTAMP_US_BITS-1:0] in_event_ts  [2];
  logic                         in_event_pol [2];

  logic                         out_valid;
  logic                         out_ready;
  logic [DVS_X_ADDR_BITS-1:0]   out_x;
  logic [DVS_Y_ADDR_BITS-1:0]   out_y;
  logic [TIMESTAMP_US_BITS-1:0] out_ts;
  logic                         out_pol;
  logic                         out_src;

  modport slave (
    input  in_new_event, in_event_x, in_event_y, in_event_ts, in_event_pol,
    input  out_ready,
    output out_valid, out_x, out_y, out_ts, out_pol, out_src
  );

  modport master (
    output in_new_event, in_event_x, in_event_y, in_event_ts, in_event_pol,
    output out_ready,
    input  out_valid, out_x, out_y, out_ts, out_pol, out_src
  );

endinterface

// File: rtl/dvs_event_arbiter_fifo.sv
// dvs_event_fifo: per-port synchronous event FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request/data; ignored when full before the edge
//   pop, dout  : read request; dout is the head entry (combinational)
//   full, empty: status from the pointer pair
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  dvs_event_t din,
  output dvs_event_t dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  dvs_event_t  mem_q [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/dvs_event_arbiter.sv
// dvs_event_arbiter: merges left (port 0) and right (port 1) DVS event
// streams into one registered valid/ready output with round-robin fairness.
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : per-port event strobes/fields in, merged event out
//   drop_count_0/1 : per-port count of events lost to a full FIFO
// FIFO_DEPTH: per-port FIFO depth, power of two in 2..16.
// Build option: define DVS_ARB_DROP_CNT_EN to enable saturating drop
// counters; otherwise both counts are tied to zero and no flops exist.
module dvs_event_arbiter
  import dvs_ravens_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dvs_event_arbiter_if.slave   bus,
  output logic [15:0]          drop_count_0,
  output logic [15:0]          drop_count_1
);

  dvs_event_t fifo_din  [2];
  dvs_event_t fifo_dout [2];
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] full;
  logic [1:0] empty;

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign fifo_din[p] = '{x:   bus.in_event_x[p],
                           y:   bus.in_event_y[p],
                           ts:  bus.in_event_ts[p],
                           pol: bus.in_event_pol[p]};
    assign push[p] = bus.in_new_event[p] && !full[p];

    dvs_event_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[p]),
      .pop   (pop[p]),
      .din   (fifo_din[p]),
      .dout  (fifo_dout[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  logic       out_valid_q, out_valid_d;
  dvs_event_t out_ev_q,    out_ev_d;
  dvs_port_e  out_src_q,   out_src_d;
  dvs_port_e  last_grant_q, last_grant_d;
  dvs_port_e  grant;
  logic       out_free;
  logic       any_ready;

  always_comb begin
    out_free  = !out_valid_q || bus.out_ready;
    any_ready = !empty[0] || !empty[1];

    // Contention goes to the port that did not win last time.
    if (!empty[0] && !empty[1]) begin
      grant = (last_grant_q == PORT_LEFT) ? PORT_RIGHT : PORT_LEFT;
    end else if (!empty[0]) begin
      grant = PORT_LEFT;
    end else begin
      grant = PORT_RIGHT;
    end

    pop          = '0;
    out_valid_d  = out_valid_q;
    out_ev_d     = out_ev_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;

    if (out_free) begin
      out_valid_d = any_ready;
      if (any_ready) begin
        if (grant == PORT_LEFT) begin
          pop[0]   = 1'b1;
          out_ev_d = fifo_dout[0];
        end else begin
          pop[1]   = 1'b1;
          out_ev_d = fifo_dout[1];
        end
        out_src_d    = grant;
        last_grant_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_ev_q     <= '0;
      out_src_q    <= PORT_LEFT;
      last_grant_q <= PORT_RIGHT;
    end else begin
      out_valid_q  <= out_valid_d;
      out_ev_q     <= out_ev_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_ev_q.x;
  assign bus.out_y     = out_ev_q.y;
  assign bus.out_ts    = out_ev_q.ts;
  assign bus.out_pol   = out_ev_q.pol;
  assign bus.out_src   = out_src_q;

`ifdef DVS_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q [2];
  logic [15:0] drop_cnt_d [2];

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      drop_cnt_d[p] = drop_cnt_q[p];
      if (bus.in_new_event[p] && full[p] && (drop_cnt_q[p] != 16'hFFFF)) begin
        drop_cnt_d[p] = drop_cnt_q[p] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q[0] <= '0;
      drop_cnt_q[1] <= '0;
    end else begin
      drop_cnt_q[0] <= drop_cnt_d[0];
      drop_cnt_q[1] <= drop_cnt_d[1];
    end
  end

  assign drop_count_0 = drop_cnt_q[0];
  assign drop_count_1 = drop_cnt_q[1];
`else
  assign drop_count_0 = '0;
  assign drop_count_1 = '0;
`endif

endmodule

// File: tb/tb_dvs_event_arbiter.sv
// tb_dvs_event_arbiter: directed bench for dvs_event_arbiter with a
// queue-based reference model compared every cycle, plus literal checks.
module tb_dvs_event_arbiter;
  import dvs_ravens_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef DVS_ARB_DROP_CNT_EN
  localparam int unsigned CNT_EN = 1;
`else
  localparam int unsigned CNT_EN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] drop_count_0;
  logic [15:0] drop_count_1;

  dvs_event_arbiter_if bus();

  dvs_event_arbiter #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .drop_count_0 (drop_count_0),
    .drop_count_1 (drop_count_1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: per-port queues and one output slot.
  dvs_event_t  mq0[$];
  dvs_event_t  mq1[$];
  bit          m_valid;
  dvs_event_t  m_ev;
  bit          m_src;
  bit          m_lg;
  int unsigned m_drop [2];

  always @(posedge clk) begin : model
    int unsigned s0, s1;
    bit          free, pick;
    dvs_event_t  ev;
    if (!rst_n) begin
      mq0.delete();
      mq1.delete();
      m_valid   = 1'b0;
      m_ev      = '0;
      m_src     = 1'b0;
      m_lg      = 1'b1;
      m_drop[0] = 0;
      m_drop[1] = 0;
    end else begin
      s0   = mq0.size();
      s1   = mq1.size();
      free = !m_valid || bus.out_ready;
      if (free) begin
        if (s0 + s1 == 0) begin
          m_valid = 1'b0;
        end else begin
          if (s0 > 0 && s1 > 0) pick = !m_lg;
          else pick = (s0 == 0);
          m_ev    = pick ? mq1.pop_front() : mq0.pop_front();
          m_src   = pick;
          m_lg    = pick;
          m_valid = 1'b1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.in_new_event[p]) begin
          ev.x   = bus.in_event_x[p];
          ev.y   = bus.in_event_y[p];
          ev.ts  = bus.in_event_ts[p];
          ev.pol = bus.in_event_pol[p];
          if (((p == 0) ? s0 : s1) < DEPTH) begin
            if (p == 0) mq0.push_back(ev);
            else mq1.push_back(ev);
          end else if (CNT_EN != 0 && m_drop[p] < 65535) begin
            m_drop[p]++;
          end
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        check("model_x",   bus.out_x,   m_ev.x);
        check("model_y",   bus.out_y,   m_ev.y);
        check("model_ts",  bus.out_ts,  m_ev.ts);
        check("model_pol", bus.out_pol, m_ev.pol);
        check("model_src", bus.out_src, m_src);
      end
      check("model_drop0", drop_count_0, m_drop[0]);
      check("model_drop1", drop_count_1, m_drop[1]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    bus.in_new_event = '0;
  endtask

  task automatic drive(input int p, input int unsigned x, input int unsigned y,
                       input int unsigned ts, input bit pol);
    bus.in_new_event[p] = 1'b1;
    bus.in_event_x[p]   = DVS_X_ADDR_BITS'(x);
    bus.in_event_y[p]   = DVS_Y_ADDR_BITS'(y);
    bus.in_event_ts[p]  = TIMESTAMP_US_BITS'(ts);
    bus.in_event_pol[p] = pol;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    idle();
    for (int p = 0; p < 2; p++) drive(p, 0, 0, 0, 1'b0);
    idle();
    step(2);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_x",     bus.out_x, 0);
    check("rst_src",   bus.out_src, 0);
    check("rst_drop0", drop_count_0, 0);

    // Single event, 2-cycle strobe-to-valid, valid for one cycle.
    drive(0, 5, 7, 100, 1'b1);
    step();
    idle();
    step();
    check("single_valid", bus.out_valid, 1);
    check("single_x",     bus.out_x, 5);
    check("single_y",     bus.out_y, 7);
    check("single_ts",    bus.out_ts, 100);
    check("single_pol",   bus.out_pol, 1);
    check("single_src",   bus.out_src, 0);
    step();
    check("single_gone",  bus.out_valid, 0);

    // Simultaneous strobes after reset: port 0 first.
    do_reset();
    drive(0, 1, 1, 1, 1'b0);
    drive(1, 2, 2, 2, 1'b1);
    step();
    idle();
    step();
    check("sim_first_src", bus.out_src, 0);
    check("sim_first_x",   bus.out_x, 1);
    step();
    check("sim_second_src", bus.out_src, 1);
    check("sim_second_x",   bus.out_x, 2);
    step();
    check("sim_done", bus.out_valid, 0);

    // Backpressure on port 1.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 10 + i, 3, 1000 + i, 1'b0);
      step();
    end
    idle();
    check("bp_hold_x", bus.out_x, 10);
    check("bp_hold_src", bus.out_src, 1);
    step(2);
    check("bp_still_x", bus.out_x, 10);
    check("bp_still_ts", bus.out_ts, 1000);
    bus.out_ready = 1'b1;
    step();
    check("bp_rel1_x", bus.out_x, 11);
    step();
    check("bp_rel2_x", bus.out_x, 12);
    step();
    check("bp_empty", bus.out_valid, 0);

    // Overflow on port 0: 1 held + 4 buffered, 1 dropped.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 20 + i, 4, 2000 + i, 1'b1);
      step();
    end
    idle();
    check("ovf_hold_x", bus.out_x, 20);
    check("ovf_drop0", drop_count_0, CNT_EN);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("ovf_drain_x", bus.out_x, 20 + i);
    end
    step();
    check("ovf_empty", bus.out_valid, 0);

    // Fairness with both FIFOs full.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 30 + i, 5, 3000 + i, 1'b0);
      drive(1, 40 + i, 6, 4000 + i, 1'b1);
      step();
    end
    idle();
    check("fair_drop1", drop_count_1, CNT_EN);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("fair_valid", bus.out_valid, 1);
      check("fair_src", bus.out_src, i % 2);
      check("fair_x", bus.out_x, (i % 2 == 0) ? 30 + i / 2 : 40 + (i - 1) / 2);
      step();
    end
    check("fair_empty", bus.out_valid, 0);

    // Reset while holding and buffering events; strobes during reset ignored.
    bus.out_ready = 1'b0;
    drive(0, 50, 1, 5000, 1'b0);
    drive(1, 60, 1, 6000, 1'b1);
    step();
    drive(0, 51, 1, 5001, 1'b0);
    drive(1, 61, 1, 6001, 1'b1);
    step();
    idle();
    drive(0, 52, 1, 5002, 1'b0);
    step();
    idle();
    check("mr_pre_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    drive(0, 99, 9, 9999, 1'b1);
    drive(1, 98, 9, 9998, 1'b1);
    step();
    rst_n = 1'b1;
    idle();
    bus.out_ready = 1'b1;
    check("mr_valid", bus.out_valid, 0);
    check("mr_x", bus.out_x, 0);
    step(4);
    check("mr_no_stale", bus.out_valid, 0);

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dvs_event_arbiter.md
DVS_EVENT_ARBITER -- requirements
Module: dvs_event_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, per-port event FIFO depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_new_event[1:0]  input  2  per-port single-cycle event strobe from receiver (port 0 = left camera, port 1 = right camera).
REQ-005 in_event_x[1:0], in_event_y[1:0], in_event_ts[1:0], in_event_pol[1:0]  input  2x DVS_X_ADDR_BITS / DVS_Y_ADDR_BITS / TIMESTAMP_US_BITS / 1  per-port event fields, valid when strobe high.
REQ-006 out_valid  output  1  merged event available.
REQ-007 out_ready  input  1  downstream accepts event when high with out_valid.
REQ-008 out_x, out_y, out_ts, out_pol, out_src  output  DVS_X_ADDR_BITS / DVS_Y_ADDR_BITS / TIMESTAMP_US_BITS / 1 / 1  merged event fields; out_src is the originating port.
REQ-009 drop_count_0, drop_count_1  output  16 each  per-port dropped-event counters.

Function
REQ-010 Each port SHALL push {x,y,ts,pol} into its own FIFO on the rising edge where in_new_event[p]=1 and that FIFO was not full before the edge.
REQ-011 An event strobed while its FIFO is full SHALL be dropped, even if a pop occurs on the same edge; the FIFO contents SHALL be unchanged by the dropped event.
REQ-012 Both ports pushing on the same edge SHALL both be accepted, subject to REQ-011.
REQ-013 The output register SHALL be "free" when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-014 On an edge where the output register is free, the arbiter SHALL pop one non-empty FIFO into the output register and set out_valid=1; if no FIFO is non-empty, out_valid SHALL clear.
REQ-015 Arbitration SHALL be round-robin: when both FIFOs are non-empty, the port not granted last SHALL win; a single non-empty FIFO always wins; a 1-bit last_grant register SHALL update only on a pop.
REQ-016 While out_valid=1 and out_ready=0, all out_* fields SHALL remain stable.
REQ-017 Latency: a strobe sampled at edge E into an empty system SHALL produce out_valid=1 after edge E+1 (2-cycle strobe-to-valid).
REQ-018 Sustained throughput SHALL be one event per cycle when out_ready is held high.
REQ-019 FIFO pointers SHALL be $clog2(FIFO_DEPTH)+1 bits, with the extra bit distinguishing full from empty; pointers SHALL wrap modulo 2*FIFO_DEPTH.
REQ-020 Per-port order SHALL be preserved; no event SHALL be duplicated.

Reset
REQ-021 With rst_n=0 at an edge: FIFOs SHALL be emptied, out_valid=0, out_x/out_y/out_ts/out_pol/out_src=0, last_grant=1 (so port 0 wins first), and drop counters=0.
REQ-022 A reset asserted mid-transfer SHALL discard all buffered and held events; strobes during reset SHALL be ignored.

Configuration
REQ-023 Macro DVS_ARB_DROP_CNT_EN defined: drop_count_p SHALL increment by 1 on each event dropped per REQ-011, saturating at 16'hFFFF.
REQ-024 Macro DVS_ARB_DROP_CNT_EN undefined: drop_count_0 and drop_count_1 SHALL be constant 0, and no counter flops SHALL be synthesized.

Structure
REQ-025 DVS_X_ADDR_BITS, DVS_Y_ADDR_BITS, and TIMESTAMP_US_BITS SHALL come from dvs_ravens_pkg; a packed struct typedef dvs_event_t {x,y,ts,pol} SHALL be added to that package.
REQ-026 The per-port FIFO SHALL be a sub-module dvs_event_fifo (push, pop, full, empty, data in/out) instantiated twice.

Verification
REQ-027 Single event: port 0 strobe at edge 1 with x=5, y=7, ts=100, pol=1, out_ready=1 -> out_valid high after edge 2 with those fields, out_src=0, for exactly one cycle.
REQ-028 Simultaneous strobes: both ports strobe on the same edge after reset -> port 0 is output first, then port 1 the next cycle.
REQ-029 Backpressure: out_ready=0 with 3 events on port 1 -> out_* hold the first event; releasing out_ready yields events in order on 3 consecutive cycles.
REQ-030 Overflow: FIFO_DEPTH=4, out_ready=0, 6 strobes on port 0 -> 1 event held in the output register + 4 in the FIFO; drop_count_0=1 with DVS_ARB_DROP_CNT_EN defined, 0 without.
REQ-031 Fairness: both FIFOs full, out_ready=1 -> out_src sequence 0,1,0,1,...
REQ-032 Mid-operation reset: rst_n=0 for one edge while out_valid=1 and FIFOs are non-empty -> out_valid=0 and FIFOs empty on the next cycle; no stale events appear afterward.
